// File: rtl/vp_sched_pkg.sv
// Shared types and constants for the video-path mode scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vp_sched_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      PENDING = 2'd1,
      BLANK   = 2'd2
   } state_t;

   localparam logic [MODE_W-1:0] MODE_BYPASS = 3'd0;
   localparam logic [MODE_W-1:0] MODE_GRAY   = 3'd1;
   localparam logic [MODE_W-1:0] MODE_BIN    = 3'd2;
   localparam logic [MODE_W-1:0] MODE_FILTER = 3'd3;
   localparam logic [MODE_W-1:0] MODE_EDGE   = 3'd4;

   // Successor mode for auto-cycling, wrapping back to mode 0.
   function automatic logic [MODE_W-1:0] next_mode_wrap(input logic [MODE_W-1:0] m,
                                                        input int num_modes);
      return (int'(m) >= num_modes - 1) ? '0 : m + 1'b1;
   endfunction

endpackage

// File: rtl/vp_sw_debounce.sv
// Switch debouncer: 2-FF synchronizer plus stability counter.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles before stable_o updates.
// Backpressure: none; the input is sampled every cycle.
// Ports: clk, rst_n (async active-low), raw_i (asynchronous switches),
//        stable_o (last value that held steady for DEBOUNCE_CYCLES cycles).
module vp_sw_debounce #(
   parameter int W               = 3,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] raw_i,
   output logic [W-1:0] stable_o
);

   localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

   logic [W-1:0]  meta_q, sync_q, prev_q, stable_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q   <= '0;
         sync_q   <= '0;
         prev_q   <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
      end else begin
         meta_q <= raw_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         // Any change restarts the count; once it saturates the value is accepted.
         if (sync_q != prev_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            stable_q <= prev_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/vp_mode_scheduler.sv
// Frame-synchronous mode scheduler for the video path; mode changes only at frame start.
// Latency: fs seen in cycle N -> mode/blank_out/switch_pulse registered in cycle N+1.
// Backpressure: none; requests wait in PENDING/BLANK until the next suitable frame start.
// Ports: clk, rst_n, v_sync_in, sw[2:0], auto_en -> mode[2:0], blank_out, switch_pulse, busy.
// Optional macro VP_SCHED_STATUS_EN adds frames_total[15:0] and switch_count[7:0].
module vp_mode_scheduler
   import vp_sched_pkg::*;
#(
   parameter int NUM_MODES       = 5,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int BLANK_FRAMES    = 2,
   parameter int FRAMES_PER_MODE = 60
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              v_sync_in,
   input  logic [MODE_W-1:0] sw,
   input  logic              auto_en,
   output logic [MODE_W-1:0] mode,
   output logic              blank_out,
   output logic              switch_pulse,
   output logic              busy
`ifdef VP_SCHED_STATUS_EN
   ,
   output logic [15:0]       frames_total,
   output logic [7:0]        switch_count
`endif
);

   localparam int             FCW        = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
   localparam logic [FCW-1:0] FRAME_LAST = FCW'((FRAMES_PER_MODE > 0) ? FRAMES_PER_MODE - 1 : 0);
   localparam int             BCW        = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
   localparam logic [BCW-1:0] BLANK_LAST = BCW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);
   localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

   logic              vs_q, fs;
   logic [1:0]        auto_sync_q;
   logic              auto_on;
   logic [MODE_W-1:0] sw_stable, sw_req;

   state_t            state_q, state_d;
   logic [MODE_W-1:0] mode_q, mode_d, next_mode_q, next_mode_d;
   logic              held_q, held_d;          // request latched during BLANK
   logic              pend_auto_q, pend_auto_d; // source of the latched request
   logic [FCW-1:0]    frame_cnt_q, frame_cnt_d, frame_inc;
   logic [BCW-1:0]    blank_cnt_q, blank_cnt_d;
   logic              blank_q, blank_d, pulse_q, pulse_d, busy_q, busy_d;
   logic              req_vld, do_switch;
   logic [MODE_W-1:0] req_mode;

   vp_sw_debounce #(.W(MODE_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (sw),
      .stable_o (sw_stable)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q        <= 1'b0;
         auto_sync_q <= '0;
      end else begin
         vs_q        <= v_sync_in;
         auto_sync_q <= {auto_sync_q[0], auto_en};
      end
   end

   assign fs      = v_sync_in & ~vs_q;
   assign auto_on = auto_sync_q[1];

   // Request decode: auto requests fire on the fs where frame_cnt reaches its last value.
   always_comb begin
      frame_inc = (frame_cnt_q == FRAME_LAST) ? frame_cnt_q : frame_cnt_q + 1'b1;
      sw_req    = (sw_stable > MODE_MAX) ? MODE_MAX : sw_stable;
      if (auto_on) begin
         req_vld  = fs && (frame_inc == FRAME_LAST) && (state_q != PENDING);
         req_mode = next_mode_wrap(mode_q, NUM_MODES);
      end else begin
         req_vld  = (sw_req != mode_q);
         req_mode = sw_req;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d     = state_q;
      next_mode_d = next_mode_q;
      held_d      = held_q;
      pend_auto_d = pend_auto_q;
      do_switch   = 1'b0;
      unique case (state_q)
         RUN: begin
            if (req_vld) begin
               next_mode_d = req_mode;
               pend_auto_d = auto_on;
               state_d     = PENDING;
            end
         end
         PENDING: begin
            // Withdrawn request: auto_en toggled, or sw went back to the current mode.
            if ((pend_auto_q != auto_on) || (!auto_on && !req_vld)) begin
               state_d = RUN;
            end else begin
               if (!auto_on) next_mode_d = req_mode;
               if (fs) begin
                  do_switch = 1'b1;
                  held_d    = 1'b0;
                  state_d   = (BLANK_FRAMES > 0) ? BLANK : RUN;
               end
            end
         end
         BLANK: begin
            if (req_vld) begin
               next_mode_d = req_mode;
               pend_auto_d = auto_on;
               held_d      = 1'b1;
            end
            if (fs && (blank_cnt_q == BLANK_LAST)) begin
               held_d  = 1'b0;
               state_d = (held_q || req_vld) ? PENDING : RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Output / datapath next values.
   always_comb begin
      mode_d      = mode_q;
      blank_d     = blank_q;
      pulse_d     = 1'b0;
      frame_cnt_d = frame_cnt_q;
      blank_cnt_d = blank_cnt_q;
      if (do_switch) begin
         mode_d      = next_mode_d;
         pulse_d     = 1'b1;
         frame_cnt_d = '0;
         blank_cnt_d = '0;
         blank_d     = (BLANK_FRAMES > 0);
      end else if (fs && (state_q != PENDING)) begin
         frame_cnt_d = frame_inc;
      end
      if ((state_q == BLANK) && fs) begin
         if (blank_cnt_q == BLANK_LAST) begin
            blank_d     = 1'b0;
            blank_cnt_d = '0;
         end else begin
            blank_cnt_d = blank_cnt_q + 1'b1;
         end
      end
      busy_d = (state_d != RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q      <= MODE_BYPASS;
         next_mode_q <= MODE_BYPASS;
         held_q      <= 1'b0;
         pend_auto_q <= 1'b0;
         frame_cnt_q <= '0;
         blank_cnt_q <= '0;
         blank_q     <= 1'b0;
         pulse_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         next_mode_q <= next_mode_d;
         held_q      <= held_d;
         pend_auto_q <= pend_auto_d;
         frame_cnt_q <= frame_cnt_d;
         blank_cnt_q <= blank_cnt_d;
         blank_q     <= blank_d;
         pulse_q     <= pulse_d;
         busy_q      <= busy_d;
      end
   end

   assign mode         = mode_q;
   assign blank_out    = blank_q;
   assign switch_pulse = pulse_q;
   assign busy         = busy_q;

`ifdef VP_SCHED_STATUS_EN
   logic [15:0] frames_total_q;
   logic [7:0]  switch_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames_total_q <= '0;
         switch_count_q <= '0;
      end else begin
         if (fs) frames_total_q <= frames_total_q + 1'b1;
         if (do_switch && (switch_count_q != 8'hFF)) switch_count_q <= switch_count_q + 1'b1;
      end
   end

   assign frames_total = frames_total_q;
   assign switch_count = switch_count_q;
`endif

endmodule

// File: tb/tb_vp_mode_scheduler.sv
// Directed bench for vp_mode_scheduler with a switch-event scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_vp_mode_scheduler;

   logic       clk;
   logic       rst_n;
   logic       v_sync_in;
   logic [2:0] sw;
   logic       auto_en;
   logic [2:0] mode;
   logic       blank_out;
   logic       switch_pulse;
   logic       busy;
`ifdef VP_SCHED_STATUS_EN
   logic [15:0] frames_total;
   logic [7:0]  switch_count;
`endif

   vp_mode_scheduler #(
      .NUM_MODES       (5),
      .DEBOUNCE_CYCLES (8),
      .BLANK_FRAMES    (2),
      .FRAMES_PER_MODE (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .v_sync_in    (v_sync_in),
      .sw           (sw),
      .auto_en      (auto_en),
      .mode         (mode),
      .blank_out    (blank_out),
      .switch_pulse (switch_pulse),
      .busy         (busy)
`ifdef VP_SCHED_STATUS_EN
      ,
      .frames_total (frames_total),
      .switch_count (switch_count)
`endif
   );

   typedef struct {
      logic [2:0] mode;
      int         blank;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One frame: v_sync high for 3 cycles, then 12 cycles of active video.
   task automatic frame(input int n);
      for (int i = 0; i < n; i++) begin
         v_sync_in = 1'b1;
         cycles(3);
         v_sync_in = 1'b0;
         cycles(12);
      end
   endtask

   task automatic expect_switch(input logic [2:0] m, input int b);
      exp_t e;
      e.mode  = m;
      e.blank = b;
      sb.push_back(e);
   endtask

   // Monitor: pops one entry per switch_pulse, checks the new mode and
   // the length (in frame starts) of the blank window that follows.
   initial begin : monitor
      exp_t e;
      bit   in_win;
      int   fr;
      int   wc;
      logic vs_p;
      in_win = 1'b0;
      fr     = 0;
      wc     = 0;
      vs_p   = 1'b0;
      e.mode = '0;
      e.blank = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_win = 1'b0;
         end else begin
            if (in_win) begin
               if (!blank_out) begin
                  chk("blank_frames", fr, e.blank);
                  in_win = 1'b0;
               end else begin
                  if (v_sync_in && !vs_p) fr++;
                  wc++;
                  if (wc > 2000) begin
                     chk("blank_window_timeout", wc, 0);
                     in_win = 1'b0;
                  end
               end
            end
            if (switch_pulse) begin
               if (sb.size() == 0) begin
                  chk("unexpected_switch_mode", int'(mode), -1);
               end else begin
                  e = sb.pop_front();
                  chk("switch_mode", int'(mode), int'(e.mode));
                  chk("switch_blank_on", int'(blank_out), (e.blank > 0) ? 1 : 0);
                  if (e.blank > 0) begin
                     in_win = 1'b1;
                     fr     = 0;
                     wc     = 0;
                  end
               end
            end
         end
         vs_p = v_sync_in;
      end
   end

   initial begin : stim
      bit seen_busy;
      bit seen_mode;
      rst_n     = 1'b0;
      v_sync_in = 1'b0;
      sw        = 3'd0;
      auto_en   = 1'b0;
      cycles(5);
      chk("rst_mode", int'(mode), 0);
      chk("rst_blank", int'(blank_out), 0);
      chk("rst_pulse", int'(switch_pulse), 0);
      chk("rst_busy", int'(busy), 0);
`ifdef VP_SCHED_STATUS_EN
      chk("rst_frames_total", int'(frames_total), 0);
      chk("rst_switch_count", int'(switch_count), 0);
`endif
      rst_n = 1'b1;
      cycles(2);
      frame(1);

      // Short glitch must never reach the scheduler.
      seen_busy = 1'b0;
      seen_mode = 1'b0;
      sw = 3'd5;
      for (int i = 0; i < 4; i++) begin
         cycles(1);
         seen_busy |= busy;
         seen_mode |= (mode != 3'd0);
      end
      sw = 3'd0;
      for (int i = 0; i < 20; i++) begin
         cycles(1);
         seen_busy |= busy;
         seen_mode |= (mode != 3'd0);
      end
      chk("glitch_busy_seen", int'(seen_busy), 0);
      chk("glitch_mode_moved", int'(seen_mode), 0);

      // sw=3: pending until the next frame start, then 2 blank frames.
      sw = 3'd3;
      cycles(20);
      chk("pend3_mode", int'(mode), 0);
      chk("pend3_busy", int'(busy), 1);
      expect_switch(3'd3, 2);
      frame(1);
      chk("sw3_mode", int'(mode), 3);
      chk("sw3_blank", int'(blank_out), 1);
      frame(2);
      chk("sw3_blank_end", int'(blank_out), 0);
      chk("sw3_busy_end", int'(busy), 0);

      // Out-of-range request clamps to the last mode.
      sw = 3'd7;
      cycles(20);
      expect_switch(3'd4, 2);
      frame(3);
      chk("clamp_mode", int'(mode), 4);

      // Auto-cycling from mode 4: wraps to 0, then 1 three frames later.
      auto_en = 1'b1;
      sw      = 3'd1;
      cycles(20);
      expect_switch(3'd0, 2);
      expect_switch(3'd1, 2);
      frame(3);
      chk("auto_wrap_mode", int'(mode), 0);
      frame(2);
      chk("auto_mode1", int'(mode), 1);
      frame(2);
      chk("auto_pending_busy", int'(busy), 1);
      auto_en = 1'b0;
      cycles(10);
      chk("auto_off_busy", int'(busy), 0);
      chk("auto_off_mode", int'(mode), 1);

      // Back to 0, then 0->2 with a new request (1) arriving mid-blank.
      sw = 3'd0;
      cycles(20);
      expect_switch(3'd0, 2);
      frame(3);
      sw = 3'd2;
      cycles(20);
      expect_switch(3'd2, 2);
      frame(1);
      sw = 3'd1;
      cycles(20);
      expect_switch(3'd1, 2);
      chk("blankreq_mode_a", int'(mode), 2);
      chk("blankreq_blank_a", int'(blank_out), 1);
      frame(1);
      chk("blankreq_mode_b", int'(mode), 2);
      chk("blankreq_blank_b", int'(blank_out), 1);
      frame(1);
      chk("blankreq_mode_c", int'(mode), 2);
      chk("blankreq_blank_c", int'(blank_out), 0);
      chk("blankreq_busy_c", int'(busy), 1);
      frame(1);
      chk("blankreq_mode_d", int'(mode), 1);
      chk("blankreq_blank_d", int'(blank_out), 1);
      frame(2);
      chk("blankreq_blank_e", int'(blank_out), 0);

      // Reset in the middle of a blank window.
      sw = 3'd3;
      cycles(20);
      expect_switch(3'd3, 2);
      frame(1);
      chk("prereset_blank", int'(blank_out), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_blank", int'(blank_out), 0);
      chk("midrst_mode", int'(mode), 0);
      chk("midrst_busy", int'(busy), 0);
`ifdef VP_SCHED_STATUS_EN
      chk("midrst_frames_total", int'(frames_total), 0);
      chk("midrst_switch_count", int'(switch_count), 0);
`endif
      cycles(3);
      rst_n = 1'b1;
      cycles(20);
      chk("postrst_mode", int'(mode), 0);
      chk("postrst_busy", int'(busy), 1);
      expect_switch(3'd3, 2);
      frame(3);
      chk("postrst_final_mode", int'(mode), 3);

      cycles(5);
      chk("scoreboard_left", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
